dct_pipe_1d: RTL and testbench

- Pipelined, handshaked 1-D forward DCT-II (VVC integer kernel) using an even/odd partial-butterfly datapath.
- Per-transaction mode: one 8-point transform, or one 4-point transform on elements 0..3.
- Optional rounded right shift at the output for stage scaling.
- Sits between the row/column buffers of the 2-D transform engine, replacing the single-cycle combinational 8-point core.

---
 rtl/dct_pipe_1d.sv | 154 +++++++++++++++
 tb/tb_dct_pipe_1d.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct_pipe_1d.sv
// rtl/dct_pipe_1d.sv - three-stage handshaked 1-D forward DCT-II (8-point or 4-point), partial butterfly
module dct_pipe_1d #(
  parameter int IN_W  = 8,
  parameter int SHIFT = 0,
  localparam int OUT_W = IN_W + 10 - SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_size4,
  input  logic [8*IN_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data
);

  localparam int EW = IN_W + 1;
  localparam int AW = IN_W + 10;

  function automatic logic signed [EW-1:0] sx(input logic signed [IN_W-1:0] a);
    return {a[IN_W-1], a};
  endfunction

  function automatic logic signed [AW-1:0] ext(input logic signed [EW-1:0] a);
    return {{(AW-EW){a[EW-1]}}, a};
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic signed [IN_W-1:0] x [8];
  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign x[g] = in_data[(7-g)*IN_W +: IN_W];
  end

  // In 4-point mode the odd terms O0/O1 ride in the even slots 2/3 so the
  // even-product bank (36/64/83) serves every 4-point coefficient.
  logic signed [EW-1:0] e_n [4];
  logic signed [EW-1:0] o_n [4];
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      e_n[j] = sx(x[j]) + sx(x[7-j]);
      o_n[j] = sx(x[j]) - sx(x[7-j]);
    end
    if (in_size4) begin
      e_n[0] = sx(x[0]) + sx(x[3]);
      e_n[1] = sx(x[1]) + sx(x[2]);
      e_n[2] = sx(x[0]) - sx(x[3]);
      e_n[3] = sx(x[1]) - sx(x[2]);
      for (int j = 0; j < 4; j++) o_n[j] = '0;
    end
  end

  logic                 v1, m1, v2, m2;
  logic signed [EW-1:0] e1 [4];
  logic signed [EW-1:0] o1 [4];

  logic signed [AW-1:0] ea [4];
  logic signed [AW-1:0] ob [4];
  logic signed [AW-1:0] p36_n [4], p64_n [4], p83_n [4];
  logic signed [AW-1:0] q18_n [4], q50_n [4], q75_n [4], q89_n [4];
  logic signed [AW-1:0] p36 [4], p64 [4], p83 [4];
  logic signed [AW-1:0] q18 [4], q50 [4], q75 [4], q89 [4];

  for (genvar g = 0; g < 4; g++) begin : g_prod
    assign ea[g]    = ext(e1[g]);
    assign ob[g]    = ext(o1[g]);
    assign p36_n[g] = (ea[g] <<< 5) + (ea[g] <<< 2);
    assign p64_n[g] = ea[g] <<< 6;
    assign p83_n[g] = (ea[g] <<< 6) + (ea[g] <<< 4) + (ea[g] <<< 1) + ea[g];
    assign q18_n[g] = (ob[g] <<< 4) + (ob[g] <<< 1);
    assign q50_n[g] = (ob[g] <<< 5) + (ob[g] <<< 4) + (ob[g] <<< 1);
    assign q75_n[g] = (ob[g] <<< 6) + (ob[g] <<< 3) + (ob[g] <<< 1) + ob[g];
    assign q89_n[g] = (ob[g] <<< 6) + (ob[g] <<< 4) + (ob[g] <<< 3) + ob[g];
  end

  logic signed [AW-1:0] acc [8];
  always_comb begin
    for (int i = 0; i < 8; i++) acc[i] = '0;
    if (m2) begin
      acc[0] = p64[0] + p64[1];
      acc[1] = p83[2] + p36[3];
      acc[2] = p64[0] - p64[1];
      acc[3] = p36[2] - p83[3];
    end else begin
      acc[0] = p64[0] + p64[1] + p64[2] + p64[3];
      acc[1] = q89[0] + q75[1] + q50[2] + q18[3];
      acc[2] = p83[0] + p36[1] - p36[2] - p83[3];
      acc[3] = q75[0] - q18[1] - q89[2] - q50[3];
      acc[4] = p64[0] - p64[1] - p64[2] + p64[3];
      acc[5] = q50[0] - q89[1] + q18[2] + q75[3];
      acc[6] = p36[0] - p83[1] + p83[2] - p36[3];
      acc[7] = q18[0] - q50[1] + q75[2] - q89[3];
    end
  end

  logic signed [OUT_W-1:0] y_n [8];
  if (SHIFT > 0) begin : g_round
    localparam logic signed [AW-1:0] RND = AW'(1) << (SHIFT - 1);
    always_comb begin
      for (int i = 0; i < 8; i++) y_n[i] = OUT_W'((acc[i] + RND) >>> SHIFT);
    end
  end else begin : g_exact
    always_comb begin
      for (int i = 0; i < 8; i++) y_n[i] = acc[i];
    end
  end

  logic [8*OUT_W-1:0] y_pack;
  always_comb begin
    y_pack = '0;
    for (int i = 0; i < 8; i++) y_pack[(7-i)*OUT_W +: OUT_W] = y_n[i];
  end

  // A stalled output freezes every stage, so no bubble is ever squeezed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      m1        <= 1'b0;
      v2        <= 1'b0;
      m2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      e1        <= '{default: '0};
      o1        <= '{default: '0};
      p36       <= '{default: '0};
      p64       <= '{default: '0};
      p83       <= '{default: '0};
      q18       <= '{default: '0};
      q50       <= '{default: '0};
      q75       <= '{default: '0};
      q89       <= '{default: '0};
    end else if (en) begin
      v1        <= in_valid;
      m1        <= in_size4;
      e1        <= e_n;
      o1        <= o_n;
      v2        <= v1;
      m2        <= m1;
      p36       <= p36_n;
      p64       <= p64_n;
      p83       <= p83_n;
      q18       <= q18_n;
      q50       <= q50_n;
      q75       <= q75_n;
      q89       <= q89_n;
      out_valid <= v2;
      out_data  <= y_pack;
    end
  end

endmodule

// File: tb/tb_dct_pipe_1d.sv
// tb/tb_dct_pipe_1d.sv - directed self-checking bench for dct_pipe_1d at SHIFT 0 and SHIFT 7
module tb_dct_pipe_1d;

  localparam int W0 = 18;
  localparam int W1 = 11;

  typedef int vec8_t [8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_size4 = 1'b0;
  logic out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic in_ready0, out_valid0, in_ready1, out_valid1;
  logic [8*W0-1:0] out_data0;
  logic [8*W1-1:0] out_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dct_pipe_1d #(.IN_W(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_size4(in_size4), .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0));

  dct_pipe_1d #(.IN_W(8), .SHIFT(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_size4(in_size4), .in_data(in_data), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1));

  int c8 [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}};
  int c4 [4][4] = '{
    '{64,  64,  64,  64},
    '{83,  36, -36, -83},
    '{64, -64, -64,  64},
    '{36, -83,  83, -36}};

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_y(input vec8_t x, input bit s4, input int sh, output vec8_t y);
    for (int r = 0; r < 8; r++) begin
      int acc;
      acc = 0;
      if (s4) begin
        if (r < 4) for (int k = 0; k < 4; k++) acc += c4[r][k] * x[k];
      end else begin
        for (int k = 0; k < 8; k++) acc += c8[r][k] * x[k];
      end
      y[r] = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
    end
  endfunction

  function automatic logic [63:0] pack(input vec8_t x);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[(7-i)*8 +: 8] = x[i][7:0];
    return p;
  endfunction

  function automatic int coef0(input int i);
    return int'($signed(out_data0[(7-i)*W0 +: W0]));
  endfunction

  function automatic int coef1(input int i);
    return int'($signed(out_data1[(7-i)*W1 +: W1]));
  endfunction

  task automatic check_hand(input string tag, input vec8_t e0, input vec8_t e1);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s_s0_y%0d", tag, i), coef0(i), e0[i]);
      check_eq($sformatf("%s_s7_y%0d", tag, i), coef1(i), e1[i]);
    end
  endtask

  task automatic check_vec(input string tag, input vec8_t x, input bit s4);
    vec8_t y0, y1;
    ref_y(x, s4, 0, y0);
    ref_y(x, s4, 7, y1);
    check_hand(tag, y0, y1);
  endtask

  // Presents one vector and leaves the caller at the negedge where it is on the output.
  task automatic send_one(input string tag, input vec8_t x, input bit s4);
    @(negedge clk);
    in_data = pack(x);
    in_size4 = s4;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, in_ready0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, out_valid0, 0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, out_valid0, 0);
    @(negedge clk);
    check_eq({tag, "_lat3"}, out_valid0, 1);
    check_eq({tag, "_lat3_s7"}, out_valid1, 1);
  endtask

  vec8_t v, e0, e1;
  vec8_t bx [6];
  bit bs4 [6];
  int idxq [$];
  bit m1, m2, m3;

  initial begin
    @(negedge clk);
    check_eq("rst_out_valid", out_valid0, 0);
    check_eq("rst_out_data", int'(out_data0 != '0), 0);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", in_ready0, 1);

    v = '{10, 10, 10, 10, 10, 10, 10, 10};
    send_one("dc", v, 1'b0);
    e0 = '{5120, 0, 0, 0, 0, 0, 0, 0};
    e1 = '{40, 0, 0, 0, 0, 0, 0, 0};
    check_hand("dc", e0, e1);

    v = '{1, 0, 0, 0, 0, 0, 0, 0};
    send_one("imp", v, 1'b0);
    e0 = '{64, 89, 83, 75, 64, 50, 36, 18};
    e1 = '{1, 1, 1, 1, 1, 0, 0, 0};
    check_hand("imp", e0, e1);

    v = '{1, 0, 0, 0, 99, 99, 99, 99};
    send_one("pt4", v, 1'b1);
    e0 = '{64, 83, 64, 36, 0, 0, 0, 0};
    e1 = '{1, 1, 1, 0, 0, 0, 0, 0};
    check_hand("pt4", e0, e1);

    v = '{-128, -128, -128, -128, -128, -128, -128, -128};
    send_one("neg", v, 1'b0);
    e0 = '{-65536, 0, 0, 0, 0, 0, 0, 0};
    e1 = '{-512, 0, 0, 0, 0, 0, 0, 0};
    check_hand("neg", e0, e1);

    bx[0] = '{3, -7, 12, 100, -128, 127, 0, -45};
    bx[1] = '{-20, 55, 9, -1, 77, 77, 77, 77};
    bx[2] = '{127, 127, -128, -128, 5, 6, 7, 8};
    bx[3] = '{1, 2, 3, 4, 5, 6, 7, 8};
    bx[4] = '{-100, 50, -25, 12, 0, 0, 0, 0};
    bx[5] = '{-128, -128, -128, -128, -128, -128, -128, 127};
    bs4 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    m1 = 0; m2 = 0; m3 = 0;
    begin
      int k, got;
      k = 0;
      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
        @(negedge clk);
        out_ready = !(c >= 4 && c <= 6);
        in_valid = (k < 6);
        if (k < 6) begin
          in_data = pack(bx[k]);
          in_size4 = bs4[k];
        end
        #1;
        check_eq($sformatf("bp_c%0d_out_valid", c), out_valid0, int'(m3));
        check_eq($sformatf("bp_c%0d_in_ready", c), in_ready0, int'(!m3 || out_ready));
        if (out_valid0) begin
          check_eq($sformatf("bp_c%0d_pending", c), int'(idxq.size() > 0), 1);
          if (idxq.size() > 0) begin
            check_vec($sformatf("bp_v%0d", idxq[0]), bx[idxq[0]], bs4[idxq[0]]);
            if (out_ready) begin
              void'(idxq.pop_front());
              got++;
            end
          end
        end
        if (in_valid && in_ready0) begin
          idxq.push_back(k);
          k++;
        end
        if (!m3 || out_ready) begin
          m3 = m2;
          m2 = m1;
          m1 = in_valid;
        end
      end
      check_eq("bp_delivered", got, 6);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      check_eq($sformatf("bp_tail%0d_out_valid", c), out_valid0, 0);
    end

    @(negedge clk);
    v = '{9, -3, 44, 0, 0, -60, 2, 1};
    in_data = pack(v);
    in_size4 = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    v = '{-5, 5, -5, 5, 0, 0, 0, 0};
    in_data = pack(v);
    in_size4 = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_out_valid_pre", out_valid0, 1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_out_valid_async", out_valid0, 0);
    check_eq("mid_out_data_async", int'(out_data0 != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst%0d_out_valid", c), out_valid0, 0);
      check_eq($sformatf("post_rst%0d_in_ready", c), in_ready0, 1);
    end
    v = '{-77, 31, 0, 8, 120, -1, -64, 13};
    send_one("post", v, 1'b0);
    check_vec("post", v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
